// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } clk_div_state_t;

  localparam int CLK_DIV_DEFAULT_W = 8;

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: near-50% div_clk plus a one-cycle tick per period.
// Latency: outputs registered; first period begins at the same edge that samples en and a nonzero div.
// Backpressure: none; the ratio is reloaded only at period end, and dropping en stops at once.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W = CLK_DIV_DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             div_clk,
  output logic             tick,
  output logic             active
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  clk_div_state_t   state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] div_q, div_q_nx;
  logic             div_clk_nx, tick_nx, active_nx;
  logic             period_end;

  // Next-state decode; outputs are derived from next-state values so they line up with the cnt they describe.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    div_q_nx   = div_q;
    period_end = (cnt == div_q - ONE);

    case (state)
      IDLE: begin
        if (en && (div != '0)) begin
          div_q_nx = div;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          // Stop wins over a coinciding period end and does not load div.
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (period_end) begin
          // Ratio is sampled only here, so a period is never truncated by a div change.
          cnt_nx   = '0;
          div_q_nx = div;
          if (div == '0) begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    active_nx  = (state_nx == RUN);
    div_clk_nx = active_nx && (cnt_nx < (div_q_nx >> 1));
    tick_nx    = active_nx && (cnt_nx == div_q_nx - ONE);
  end

  // State, counter, ratio latch and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      div_q   <= div_q_nx;
      div_clk <= div_clk_nx;
      tick    <= tick_nx;
      active  <= active_nx;
    end
  end

endmodule
